// File: rtl/accel_pkg.sv
// Shared types and helpers for the layer sequencer: state encoding, stage
// indices and the next-enabled-stage lookup.
package accel_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MATMUL = 3'd1,
    S_NORM   = 3'd2,
    S_ACT    = 3'd3,
    S_POOL   = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  localparam logic [1:0] STG_MATMUL = 2'd0;
  localparam logic [1:0] STG_NORM   = 2'd1;
  localparam logic [1:0] STG_ACT    = 2'd2;
  localparam logic [1:0] STG_POOL   = 2'd3;

  // Stage states are encoded as stage index + 1, so the raw value of cur
  // (IDLE included) is the first stage index still eligible to run.
  function automatic state_e next_stage(input state_e cur, input logic [3:0] cfg);
    state_e      nxt;
    int unsigned idx;
    nxt = S_DONE;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = 3 - i;
      if (idx >= 32'(cur) && cfg[idx[1:0]]) nxt = state_e'(3'(idx + 1));
    end
    return nxt;
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Host/config and datapath handshake bundle of the layer sequencer.
interface layer_sequencer_if #(
  parameter int unsigned TIMEOUT_W = 16,
  parameter int unsigned CNT_W     = 32
);
  logic                 start;
  logic                 abort;
  logic                 enable_matmul;
  logic                 enable_norm;
  logic                 enable_activation;
  logic                 enable_pool;
  logic [TIMEOUT_W-1:0] timeout_limit;
  logic                 done_matmul;
  logic                 done_norm;
  logic                 done_activation;
  logic                 done_pool;
  logic                 start_mat_mul;
  logic                 start_norm;
  logic                 start_activation;
  logic                 start_pool;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [1:0]           err_stage;
  logic [CNT_W-1:0]     cycle_count;

  modport master (
    output start, abort, enable_matmul, enable_norm, enable_activation, enable_pool,
           timeout_limit, done_matmul, done_norm, done_activation, done_pool,
    input  start_mat_mul, start_norm, start_activation, start_pool,
           busy, done, error, err_stage, cycle_count
  );

  modport slave (
    input  start, abort, enable_matmul, enable_norm, enable_activation, enable_pool,
           timeout_limit, done_matmul, done_norm, done_activation, done_pool,
    output start_mat_mul, start_norm, start_activation, start_pool,
           busy, done, error, err_stage, cycle_count
  );
endinterface

// File: rtl/layer_sequencer_watchdog.sv
// Per-stage watchdog: counts cycles since the last clear and flags when the
// programmed limit is about to be reached (limit of zero disables it).
module stage_watchdog #(
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 count_en,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expired
);
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)         cnt_d = '0;
    else if (count_en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = (limit != '0) && (cnt_q == limit - 1'b1);
endmodule

// File: rtl/layer_sequencer.sv
// Runs one layer through matmul, norm, activation and pool, skipping stages
// whose latched enable is clear and trapping in ERROR on a stage timeout.
module layer_sequencer
  import accel_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 16,
  parameter int unsigned CNT_W     = 32
) (
  input logic              clk,
  input logic              reset,
  layer_sequencer_if.slave sif
);
  state_e           state_q, state_d;
  logic [3:0]       cfg_q, cfg_d;
  logic [1:0]       err_stage_q, err_stage_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       live_cfg;
  logic             in_stage, stage_done, wd_clear, wd_expired;

  assign live_cfg = {sif.enable_pool, sif.enable_activation, sif.enable_norm, sif.enable_matmul};
  assign in_stage = state_q inside {[S_MATMUL:S_POOL]};

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    err_stage_d = err_stage_q;
    cnt_d       = cnt_q;
    stage_done  = 1'b0;
    case (state_q)
      S_MATMUL: stage_done = sif.done_matmul;
      S_NORM:   stage_done = sif.done_norm;
      S_ACT:    stage_done = sif.done_activation;
      S_POOL:   stage_done = sif.done_pool;
      default:  stage_done = 1'b0;
    endcase

    if (sif.abort) begin
      state_d     = S_IDLE;
      err_stage_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (sif.start) begin
          cfg_d   = live_cfg;
          cnt_d   = '0;
          state_d = next_stage(S_IDLE, live_cfg);
        end
        S_MATMUL, S_NORM, S_ACT, S_POOL: begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          // done has priority over a watchdog expiry in the same cycle
          if (stage_done) begin
            state_d = next_stage(state_q, cfg_q);
          end else if (wd_expired) begin
            state_d     = S_ERROR;
            err_stage_d = 2'(state_q - 3'd1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERROR: state_d = S_ERROR;
        default: state_d = S_IDLE;
      endcase
    end

    wd_clear = (state_d != state_q) && (state_d inside {[S_MATMUL:S_POOL]});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cfg_q       <= '0;
      err_stage_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      err_stage_q <= err_stage_d;
      cnt_q       <= cnt_d;
    end
  end

  stage_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (wd_clear),
    .count_en (in_stage),
    .limit    (sif.timeout_limit),
    .expired  (wd_expired)
  );

  assign sif.start_mat_mul    = (state_q == S_MATMUL);
  assign sif.start_norm       = (state_q == S_NORM);
  assign sif.start_activation = (state_q == S_ACT);
  assign sif.start_pool       = (state_q == S_POOL);
  assign sif.busy             = in_stage;
  assign sif.done             = (state_q == S_DONE);
  assign sif.error            = (state_q == S_ERROR);
  assign sif.err_stage        = err_stage_q;
  assign sif.cycle_count      = cnt_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized bench for layer_sequencer: each layer is turned into an expected
// per-cycle timeline from the stage rules and compared cycle by cycle.
module tb_layer_sequencer;
  localparam int unsigned TW = 16;
  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] CMAX = '1;

  typedef struct {
    logic [3:0]  st;
    logic        busy;
    logic        dn;
    logic        er;
    logic [1:0]  es;
    int unsigned cnt;
    int          drv;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned lat [4];
  exp_t tl[$];

  always #5 clk = ~clk;

  layer_sequencer_if #(.TIMEOUT_W(TW), .CNT_W(CW)) sif ();

  layer_sequencer #(.TIMEOUT_W(TW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [CW-1:0] sat(input int unsigned v);
    return (v > 32'(CMAX)) ? CMAX : v[CW-1:0];
  endfunction

  function automatic logic [31:0] observe();
    return 32'({sif.start_pool, sif.start_activation, sif.start_norm, sif.start_mat_mul,
                sif.busy, sif.done, sif.error, sif.err_stage, sif.cycle_count});
  endfunction

  function automatic logic [31:0] pack_exp(input exp_t e);
    return 32'({e.st, e.busy, e.dn, e.er, e.es, sat(e.cnt)});
  endfunction

  function automatic exp_t idle_exp(input int unsigned cnt);
    exp_t e;
    e.st = '0; e.busy = 1'b0; e.dn = 1'b0; e.er = 1'b0; e.es = '0; e.cnt = cnt; e.drv = -1;
    return e;
  endfunction

  task automatic set_dones(input logic [3:0] v);
    {sif.done_pool, sif.done_activation, sif.done_norm, sif.done_matmul} = v;
  endtask

  // Expected behaviour from the stage rules: an enabled stage lasts its
  // latency, or exactly lim cycles when the latency exceeds a nonzero limit.
  task automatic build_timeline(input logic [3:0] cfg, input int unsigned lim);
    exp_t        e;
    int unsigned k;
    bit          to;
    logic [1:0]  tos;
    k = 0; to = 1'b0; tos = '0;
    tl.delete();
    for (int unsigned i = 0; i < 4; i++) begin
      if (cfg[i] && !to) begin
        int unsigned dur;
        to  = (lim != 0) && (lat[i] > lim);
        dur = to ? lim : lat[i];
        if (to) tos = 2'(i);
        for (int unsigned j = 1; j <= dur; j++) begin
          e.st = 4'(1 << i); e.busy = 1'b1; e.dn = 1'b0; e.er = 1'b0; e.es = '0;
          e.cnt = k; e.drv = (!to && j == dur) ? int'(i) : -1;
          tl.push_back(e);
          k++;
        end
      end
    end
    e.st = '0; e.busy = 1'b0; e.dn = !to; e.er = to; e.es = to ? tos : 2'd0;
    e.cnt = k; e.drv = -1;
    tl.push_back(e);
  endtask

  task automatic run_layer(input int unsigned id, input logic [3:0] cfg, input int unsigned lim,
                           input int abort_at, input bit noise);
    logic [3:0] dv;
    exp_t       last;
    build_timeline(cfg, lim);
    last = tl[tl.size()-1];
    {sif.enable_pool, sif.enable_activation, sif.enable_norm, sif.enable_matmul} = cfg;
    sif.timeout_limit = TW'(lim);
    set_dones('0);
    sif.start = 1'b1;
    for (int unsigned k = 0; k < tl.size(); k++) begin
      @(negedge clk);
      sif.start = 1'b0;
      check_eq($sformatf("layer%0d_cyc%0d", id, k), observe(), pack_exp(tl[k]));
      if (noise) begin
        dv = 4'($urandom);
        {sif.enable_pool, sif.enable_activation, sif.enable_norm, sif.enable_matmul} = 4'($urandom);
        if (tl[k].st != '0) sif.start = 1'($urandom);
      end else begin
        dv = '0;
      end
      dv = dv & ~tl[k].st;
      if (tl[k].drv >= 0) dv[tl[k].drv[1:0]] = 1'b1;
      set_dones(dv);
      if (abort_at == int'(k)) begin
        sif.abort = 1'b1;
        sif.start = 1'b1;
        @(negedge clk);
        sif.abort = 1'b0;
        sif.start = 1'b0;
        check_eq($sformatf("layer%0d_abort", id), observe(), pack_exp(idle_exp(tl[k].cnt)));
        return;
      end
    end
    sif.start = 1'b0;
    if (last.er) begin
      sif.start = 1'b1;
      @(negedge clk);
      check_eq($sformatf("layer%0d_err_hold", id), observe(), pack_exp(last));
      sif.abort = 1'b1;
      @(negedge clk);
      sif.abort = 1'b0;
      sif.start = 1'b0;
      check_eq($sformatf("layer%0d_err_abort", id), observe(), pack_exp(idle_exp(last.cnt)));
    end else begin
      @(negedge clk);
      set_dones('0);
      check_eq($sformatf("layer%0d_idle", id), observe(), pack_exp(idle_exp(last.cnt)));
    end
  endtask

  initial begin
    reset = 1'b1;
    sif.start = 1'b0; sif.abort = 1'b0; sif.timeout_limit = '0;
    {sif.enable_pool, sif.enable_activation, sif.enable_norm, sif.enable_matmul} = '0;
    set_dones('0);
    repeat (3) @(negedge clk);
    check_eq("reset_state", observe(), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    lat = '{5, 5, 5, 5};    run_layer(1, 4'b1111, 0, -1, 1'b0);
    lat = '{7, 3, 7, 4};    run_layer(2, 4'b1010, 0, -1, 1'b0);
    run_layer(3, 4'b0000, 0, -1, 1'b0);
    lat = '{2, 3, 100, 2};  run_layer(4, 4'b1111, 8, -1, 1'b0);
    lat = '{1, 4, 2, 1};    run_layer(5, 4'b1111, 4, -1, 1'b0);
    lat = '{3, 4, 5, 6};    run_layer(6, 4'b0101, 0, -1, 1'b1);
    lat = '{3, 2, 4, 1};    run_layer(7, 4'b1001, 1, -1, 1'b0);
    lat = '{20, 20, 20, 20}; run_layer(8, 4'b1111, 0, -1, 1'b0);

    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_reset", observe(), 32'd0);
    reset = 1'b0;

    for (int unsigned n = 0; n < 40; n++) begin
      int unsigned lim;
      int          ab;
      for (int unsigned s = 0; s < 4; s++) lat[s] = $urandom_range(1, 12);
      lim = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 10);
      ab  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 25)) : -1;
      run_layer(100 + n, 4'($urandom), lim, ab, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Sequences one layer through the accelerator datapath: matrix multiply, then normalization, then activation, then pooling. Each stage runs only if its enable bit is set. The block latches the per-layer stage enables at start and issues a level start to each enabled stage in order. It waits for that stage's done, skips disabled stages, and guards every stage with a programmable watchdog. It replaces ad hoc top-level sequencing and sits between the host/config interface and the datapath units.

## Interface
Parameters:
- TIMEOUT_W, 16: watchdog counter and limit width.
- CNT_W, 32: layer cycle-counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  layer request; sampled only in IDLE.
- abort  in  1  synchronous return to IDLE from any state.
- enable_matmul, enable_norm, enable_activation, enable_pool  in  1 each  stage enables, latched on accepted start.
- timeout_limit  in  TIMEOUT_W  per-stage cycle limit; 0 disables the watchdog.
- done_matmul, done_norm, done_activation, done_pool  in  1 each  stage completion, level or pulse.
- start_mat_mul, start_norm, start_activation, start_pool  out  1 each  stage start, held high while the stage is active.
- busy  out  1  high in any stage state.
- done  out  1  one-cycle pulse on layer completion.
- error  out  1  sticky watchdog error.
- err_stage  out  2  stage that timed out: 0 = matmul, 1 = norm, 2 = act, 3 = pool.
- cycle_count  out  CNT_W  cycles from accepted start to done; saturating.

## Operation
- States: IDLE, MATMUL, NORM, ACT, POOL, DONE, ERROR.
- Reset and abort: state goes to IDLE. All starts, busy, done and error go to 0; err_stage goes to 0. cycle_count goes to 0 on reset only; abort leaves it unchanged.
- IDLE with start=1:
  - Latch the four enables into cfg.
  - Clear cycle_count.
  - Go to the first enabled stage in the order MATMUL, NORM, ACT, POOL.
  - If no stage is enabled, go straight to DONE.
- start while not in IDLE is ignored; it is neither queued nor an error.
- Stage state X:
  - start_X = 1; all other starts are 0.
  - When done_X = 1, go to the next enabled stage after X, or to DONE if none remains.
  - done inputs of non-current stages are ignored.
- Watchdog:
  - Counter clears on every stage entry and increments each cycle in the stage.
  - If timeout_limit != 0 and the counter equals timeout_limit - 1 while done_X = 0, go to ERROR. err_stage = X and error = 1.
  - If done_X and the timeout arrive in the same cycle, done wins.
- DONE: done = 1 for exactly one cycle, then IDLE. cycle_count freezes.
- ERROR: all starts are 0 and busy = 0. Stays in ERROR, ignoring start, until reset or abort.
- cycle_count:
  - Increments every cycle in the stage states.
  - Saturates at all-ones.
  - Holds its value in DONE, IDLE and ERROR.
- The cfg register is stable for the whole layer; changes on the enable inputs mid-layer have no effect.

## Timing
- All outputs are registered.
- Start accepted at edge N:
  - start_X and busy are high from N+1.
  - cycle_count = 1 after edge N+1.
- done_X sampled high at edge K:
  - start_X is low from K+1.
  - The next stage's start is high from K+1, with no gap cycle between stages.
  - The transition into DONE also occurs at K+1.
- done pulse: high exactly at cycle K+1 for the last stage; IDLE from K+2.
- Back-to-back layers: start sampled at K+2 is accepted, so a new layer can begin every stage-latency + 2 cycles.
- Timeout with timeout_limit = T: start_X is high for exactly T cycles, then ERROR. error is high from the next edge.
- Empty layer (no enables): start at N, done pulse at N+1, busy never asserts, cycle_count = 0.
- abort has priority over start and done in the same cycle. reset has priority over everything.

## Structure
- Shared package (accel_pkg):
  - State encoding: 3-bit localparams for the seven states.
  - Stage index constants: STG_MATMUL = 0, STG_NORM = 1, STG_ACT = 2, STG_POOL = 3.
  - Next-enabled-stage function: takes the current stage and cfg, returns the next stage or DONE.
- Sub-module stage_watchdog: clear, count enable, limit, expired flag; parameterized by TIMEOUT_W.
- Everything else (FSM, cfg latch, cycle counter) lives in layer_sequencer.

## Test plan
- All enables = 1, each done pulsed 5 cycles after its start rises, timeout_limit = 0 -> start_mat_mul, start_norm, start_activation and start_pool each high for 5 cycles, back to back; done pulses at cycle 21 after start; cycle_count = 20.
- Only enable_norm and enable_pool set -> start_mat_mul and start_activation never rise; NORM is entered at N+1 and POOL directly after done_norm.
- No enables, start pulse -> done pulses one cycle later; busy stays 0; cycle_count = 0.
- timeout_limit = 8, done_activation never asserted -> start_activation high for 8 cycles, then error = 1 and err_stage = 2; a later start is ignored; abort clears error and returns to IDLE.
- done_norm asserted in the same cycle the watchdog expires (limit 4, done on the 4th cycle) -> no error; the sequence advances to ACT.
- Enables toggled mid-layer and a second start issued while busy -> the layer follows the latched cfg, the second start is ignored, and a start issued one cycle after the done pulse is accepted.
